// File: rtl/cam_cmd_initiator_if.sv
// Request/response handshake bundle between a lookup client (master) and the
// CAM command initiator (slave).
interface cam_cmd_initiator_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [IDX_W-1:0]  req_index;
    logic [DATA_W-1:0] req_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_hit;
    logic [IDX_W-1:0]  rsp_index;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req_valid, req_op, req_index, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_index, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_index, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_index, rsp_data
    );
endinterface

// File: rtl/cam_cmd_initiator.sv
// Initiator front end for the 32x32 CAM: queues requests, runs one CAM operation at a time
// and returns one response per request. Define CAM_HIT_STATS_EN for search/insert hit/miss counters.
module cam_cmd_initiator #(
    parameter int DATA_W     = 32,
    parameter int IDX_W      = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int RSP_LAT    = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    cam_cmd_initiator_if.slave cmd,
    output logic              cam_read_enable_o,
    output logic [IDX_W-1:0]  cam_read_index_o,
    output logic              cam_write_enable_o,
    output logic [IDX_W-1:0]  cam_write_index_o,
    output logic [DATA_W-1:0] cam_write_data_o,
    output logic              cam_search_enable_o,
    output logic [DATA_W-1:0] cam_search_data_o,
    input  logic              cam_read_valid_i,
    input  logic [DATA_W-1:0] cam_read_value_i,
    input  logic              cam_search_valid_i,
    input  logic [IDX_W-1:0]  cam_search_index_i,
    output logic [IDX_W-1:0]  alloc_ptr_o
`ifdef CAM_HIT_STATS_EN
    ,
    output logic [15:0]       hit_cnt_o,
    output logic [15:0]       miss_cnt_o
`endif
);

    typedef enum logic [1:0] {
        OP_READ   = 2'b00,
        OP_WRITE  = 2'b01,
        OP_SEARCH = 2'b10,
        OP_INSERT = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        INS_WR,
        RESP
    } state_e;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = (RSP_LAT > 1) ? $clog2(RSP_LAT) : 1;

    op_e               fifo_op    [FIFO_DEPTH];
    logic [IDX_W-1:0]  fifo_index [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              push;
    logic              pop;

    state_e            state;
    op_e               op_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  wait_cnt;

    assign cmd.req_ready = (count != (PTR_W+1)'(FIFO_DEPTH));
    assign push          = cmd.req_valid && cmd.req_ready;
    assign pop           = (state == IDLE) && (count != '0);

    // Payload storage needs no reset: only entries covered by count are ever read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_op[wr_ptr]    <= op_e'(cmd.req_op);
            fifo_index[wr_ptr] <= cmd.req_index;
            fifo_data[wr_ptr]  <= cmd.req_data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Strobes are registered and set on entry to ISSUE/INS_WR, so each lasts exactly one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state               <= IDLE;
            op_q                <= OP_READ;
            idx_q               <= '0;
            data_q              <= '0;
            wait_cnt            <= '0;
            cam_read_enable_o   <= 1'b0;
            cam_read_index_o    <= '0;
            cam_write_enable_o  <= 1'b0;
            cam_write_index_o   <= '0;
            cam_write_data_o    <= '0;
            cam_search_enable_o <= 1'b0;
            cam_search_data_o   <= '0;
            cmd.rsp_valid       <= 1'b0;
            cmd.rsp_hit         <= 1'b0;
            cmd.rsp_index       <= '0;
            cmd.rsp_data        <= '0;
            alloc_ptr_o         <= '0;
        end else begin
            cam_read_enable_o   <= 1'b0;
            cam_write_enable_o  <= 1'b0;
            cam_search_enable_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        op_q   <= fifo_op[rd_ptr];
                        idx_q  <= fifo_index[rd_ptr];
                        data_q <= fifo_data[rd_ptr];
                        case (fifo_op[rd_ptr])
                            OP_READ: begin
                                cam_read_enable_o <= 1'b1;
                                cam_read_index_o  <= fifo_index[rd_ptr];
                            end
                            OP_WRITE: begin
                                cam_write_enable_o <= 1'b1;
                                cam_write_index_o  <= fifo_index[rd_ptr];
                                cam_write_data_o   <= fifo_data[rd_ptr];
                            end
                            default: begin
                                cam_search_enable_o <= 1'b1;
                                cam_search_data_o   <= fifo_data[rd_ptr];
                            end
                        endcase
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (op_q == OP_WRITE) begin
                        cmd.rsp_valid <= 1'b1;
                        cmd.rsp_hit   <= 1'b1;
                        cmd.rsp_index <= idx_q;
                        cmd.rsp_data  <= data_q;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= CNT_W'(RSP_LAT - 1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        case (op_q)
                            OP_READ: begin
                                cmd.rsp_valid <= 1'b1;
                                cmd.rsp_hit   <= cam_read_valid_i;
                                cmd.rsp_index <= idx_q;
                                cmd.rsp_data  <= cam_read_value_i;
                                state         <= RESP;
                            end
                            OP_INSERT: begin
                                if (cam_search_valid_i) begin
                                    cmd.rsp_valid <= 1'b1;
                                    cmd.rsp_hit   <= 1'b1;
                                    cmd.rsp_index <= cam_search_index_i;
                                    cmd.rsp_data  <= data_q;
                                    state         <= RESP;
                                end else begin
                                    cam_write_enable_o <= 1'b1;
                                    cam_write_index_o  <= alloc_ptr_o;
                                    cam_write_data_o   <= data_q;
                                    state              <= INS_WR;
                                end
                            end
                            default: begin
                                cmd.rsp_valid <= 1'b1;
                                cmd.rsp_hit   <= cam_search_valid_i;
                                cmd.rsp_index <= cam_search_index_i;
                                cmd.rsp_data  <= data_q;
                                state         <= RESP;
                            end
                        endcase
                    end
                end
                INS_WR: begin
                    // Round-robin allocation: wrapping past the last slot overwrites the oldest insert.
                    cmd.rsp_valid <= 1'b1;
                    cmd.rsp_hit   <= 1'b0;
                    cmd.rsp_index <= alloc_ptr_o;
                    cmd.rsp_data  <= data_q;
                    alloc_ptr_o   <= alloc_ptr_o + 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (cmd.rsp_ready) begin
                        cmd.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CAM_HIT_STATS_EN
    logic stat_final;
    logic stat_hit;
    logic stat_miss;

    assign stat_final = (state == WAIT) && (wait_cnt == '0) &&
                        ((op_q == OP_SEARCH) || (op_q == OP_INSERT));
    assign stat_hit   = stat_final && cam_search_valid_i;
    assign stat_miss  = (stat_final && !cam_search_valid_i && (op_q == OP_SEARCH)) ||
                        (state == INS_WR);

    // An insert miss is counted when its write is issued, which is when its response is formed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (stat_hit && (hit_cnt_o != 16'hFFFF))   hit_cnt_o  <= hit_cnt_o + 1'b1;
            if (stat_miss && (miss_cnt_o != 16'hFFFF)) miss_cnt_o <= miss_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: doc/cam_cmd_initiator.md
Name: cam_cmd_initiator

Overview:
- Initiator-side front end for the 32x32 CAM: accepts queued read/write/search/insert requests over a valid/ready port and drives the CAM request pins one operation at a time.
- Samples CAM responses, composes one result per request and returns it over a valid/ready response port.
- Replaces the bench-driven clocking-block stimulus as the in-design master of the CAM. Sits between the lookup client and the cam top level.

Parameters:
- DATA_W, 32, CAM word width.
- IDX_W, 5, CAM index width (2**IDX_W entries).
- FIFO_DEPTH, 4, request FIFO entries (power of two, >=2).
- RSP_LAT, 1, cycles from CAM enable pulse to sampled read/search outputs.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  asynchronous active-high reset.
- req_valid_i  in  1  request offered.
- req_ready_o  out  1  FIFO not full.
- req_op_i  in  2  00 read, 01 write, 10 search, 11 insert.
- req_index_i  in  IDX_W  read/write index.
- req_data_i  in  DATA_W  write/search/insert data.
- rsp_valid_o  out  1  response held.
- rsp_ready_i  in  1  response consumed.
- rsp_hit_o  out  1  read: entry valid; search/insert: match; write: 1.
- rsp_index_o  out  IDX_W  resolved index.
- rsp_data_o  out  DATA_W  read value, else echoed request data.
- cam_read_enable_o  out  1  CAM read strobe.
- cam_read_index_o  out  IDX_W  CAM read index.
- cam_write_enable_o  out  1  CAM write strobe.
- cam_write_index_o  out  IDX_W  CAM write index.
- cam_write_data_o  out  DATA_W  CAM write data.
- cam_search_enable_o  out  1  CAM search strobe.
- cam_search_data_o  out  DATA_W  CAM search key.
- cam_read_valid_i  in  1  CAM read_valid_o.
- cam_read_value_i  in  DATA_W  CAM read_value_o.
- cam_search_valid_i  in  1  CAM search_valid_o.
- cam_search_index_i  in  IDX_W  CAM search_index_o.
- alloc_ptr_o  out  IDX_W  next insert-miss slot.

Behaviour:
- Clock and reset: single clock clk_i. rst_i is asynchronous, active-high.
- Reset state: FIFO empty, req_ready_o=1, state IDLE. All cam_*_enable_o=0 and all cam index/data outputs 0. rsp_valid_o=0, rsp_hit_o=0, rsp_index_o=0, rsp_data_o=0, alloc_ptr_o=0.
- Reset mid-operation: an assertion mid-operation drops all strobes in the same cycle (asynchronously). The in-flight request and all queued requests are discarded with no response.
- FIFO push: when req_valid_i && req_ready_o at a clock edge. Push and pop in the same cycle are allowed.
- FIFO full: req_ready_o=0 and the offer is ignored.
- Request accept to first CAM strobe: minimum 1 cycle (IDLE pops the head the edge after it becomes non-empty).
- FSM states:
  - IDLE: FIFO non-empty -> ISSUE (head popped into an op register).
  - ISSUE: assert exactly one strobe for 1 cycle.
    - read: read_enable with index.
    - write: write_enable with index and data.
    - search/insert: search_enable with data.
    - write -> RESP. Others -> WAIT.
  - WAIT: count RSP_LAT cycles, then sample the CAM response in the final cycle.
    - read: hit = read_valid, data = read_value.
    - search: hit = search_valid, index = search_index.
    - insert hit -> RESP with hit=1, index = search_index.
    - insert miss -> INS_WR.
  - INS_WR: 1-cycle write_enable at alloc_ptr_o with data. Response hit=0, index = old alloc_ptr_o. alloc_ptr_o increments, wrapping 2**IDX_W-1 -> 0 (old contents overwritten). -> RESP.
  - RESP: rsp_valid_o=1 with fields stable until rsp_ready_i is sampled high. Then -> IDLE. The next ISSUE is no earlier than the following cycle.
- Strobe rules: strobes are mutually exclusive and never asserted outside ISSUE/INS_WR. Index/data outputs hold their last value when strobes are low.
- Ordering: strictly one CAM operation outstanding. Responses are returned in request order.
- Ignored fields: req_index_i is ignored for search and insert. req_data_i is ignored for read.

Optional Feature:
- CAM_HIT_STATS_EN defined: adds outputs hit_cnt_o[15:0] and miss_cnt_o[15:0].
  - Incremented on each search/insert response: hit or miss respectively.
  - Saturating at 16'hFFFF.
  - Cleared by rst_i.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, write idx 3 data 32'hDEADBEEF, then read idx 3 -> cam_write_enable_o 1 cycle at idx 3. Read response hit=1, data=32'hDEADBEEF.
- Search 32'hDEADBEEF after that write -> hit=1, index=3. Search 32'h12345678 -> hit=0, no CAM write strobe.
- Insert 32'hA5A5A5A5 (miss) from reset -> write at idx 0, rsp hit=0 index=0, alloc_ptr_o=1. Repeat the same insert -> hit=1, index=0, alloc_ptr_o stays 1.
- 33 distinct inserts from reset -> 33rd writes idx 0 again, alloc_ptr_o wraps to 1. Searching the first key then misses.
- Hold rsp_ready_i=0 and push 5 requests -> req_ready_o drops after the 5th accept (4 queued + 1 in RESP). rsp fields stay stable. Releasing rsp_ready_i yields 5 in-order responses.
- Assert rst_i during WAIT of a search with 2 queued -> strobes 0 immediately, rsp_valid_o=0, req_ready_o=1. No stale response after release.
